motoro3_ramp_ctrl: RTL and testbench

MOTORO3_RAMP_CTRL -- requirements
Module: motoro3_ramp_ctrl

---
 rtl/motoro3_ramp_ctrl_if.sv | 11 +
 rtl/motoro3_ramp_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_motoro3_ramp_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/motoro3_ramp_ctrl_if.sv
// Command handshake between the host sequencer and the motor ramp controller.
interface motoro3_ramp_ctrl_if;
    logic       valid;
    logic       ready;
    logic       run;
    logic       dir;
    logic [9:0] freq;

    modport master (output valid, output run, output dir, output freq, input ready);
    modport slave  (input valid, input run, input dir, input freq, output ready);
endinterface

// File: rtl/motoro3_ramp_ctrl.sv
// Spin-up / spin-down sequencer for the motor-driver bridge: ramps the frequency
// word one LSB per step, reverses via a full stop plus dwell, and honours estop.
module motoro3_ramp_ctrl #(
    parameter logic [9:0]  FREQ_MIN  = 10'd1000,
    parameter logic [9:0]  FREQ_SLOW = 10'd1023,
    parameter int unsigned RAMP_DIV  = 1000,
    parameter int unsigned DWELL_CYC = 10000
) (
    input  logic                      clk,
    input  logic                      nRst,
    motoro3_ramp_ctrl_if.slave        cmd,
    input  logic                      estop,
    output logic                      m3start,
    output logic                      m3inv_or_stop,
    output logic [9:0]                m3freq,
    output logic                      at_speed,
    output logic [2:0]                state
);
    localparam int unsigned STEP_W  = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
    localparam int unsigned DWELL_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        RUN   = 3'd2,
        DECEL = 3'd3,
        DWELL = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         freq_q, freq_d;
    logic [9:0]         target_q, target_d;
    logic [9:0]         pend_target_q, pend_target_d;
    logic               start_q, start_d;
    logic               dir_q, dir_d;
    logic               pend_dir_q, pend_dir_d;
    logic               pend_q, pend_d;
    logic               at_speed_q, at_speed_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic       accept;
    logic       step_hit;
    logic [9:0] cmd_target;

    // Commands are only taken while a ramp can still be redirected and estop is clear.
    assign cmd.ready  = ((state_q == IDLE) || (state_q == RAMP) || (state_q == RUN)) && !estop;
    assign accept     = cmd.valid && cmd.ready;
    assign cmd_target = (cmd.freq < FREQ_MIN) ? FREQ_MIN : cmd.freq;
    assign step_hit   = (step_q == STEP_W'(RAMP_DIV - 1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q       <= IDLE;
            freq_q        <= FREQ_SLOW;
            target_q      <= FREQ_SLOW;
            pend_target_q <= FREQ_SLOW;
            start_q       <= 1'b0;
            dir_q         <= 1'b0;
            pend_dir_q    <= 1'b0;
            pend_q        <= 1'b0;
            at_speed_q    <= 1'b0;
            step_q        <= '0;
            dwell_q       <= '0;
        end else begin
            state_q       <= state_d;
            freq_q        <= freq_d;
            target_q      <= target_d;
            pend_target_q <= pend_target_d;
            start_q       <= start_d;
            dir_q         <= dir_d;
            pend_dir_q    <= pend_dir_d;
            pend_q        <= pend_d;
            at_speed_q    <= at_speed_d;
            step_q        <= step_d;
            dwell_q       <= dwell_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        freq_d        = freq_q;
        target_d      = target_q;
        pend_target_d = pend_target_q;
        start_d       = start_q;
        dir_d         = dir_q;
        pend_dir_d    = pend_dir_q;
        pend_d        = pend_q;
        step_d        = step_hit ? '0 : step_q + STEP_W'(1);
        dwell_d       = dwell_q;

        if (accept) begin
            step_d = '0;
        end

        if (estop) begin
            // Dwell counter stays pinned at 0 for as long as estop is held.
            state_d = DWELL;
            start_d = 1'b0;
            freq_d  = FREQ_SLOW;
            pend_d  = 1'b0;
            dwell_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && cmd.run) begin
                        state_d  = RAMP;
                        freq_d   = FREQ_SLOW;
                        dir_d    = cmd.dir;
                        start_d  = 1'b1;
                        target_d = cmd_target;
                    end
                end
                RAMP, RUN: begin
                    if (accept) begin
                        if (!cmd.run) begin
                            pend_d  = 1'b0;
                            state_d = DECEL;
                        end else if (cmd.dir == dir_q) begin
                            target_d = cmd_target;
                            state_d  = RAMP;
                        end else begin
                            // Reversal goes through a full stop; remember where to go next.
                            pend_target_d = cmd_target;
                            pend_dir_d    = cmd.dir;
                            pend_d        = 1'b1;
                            state_d       = DECEL;
                        end
                    end else if (state_q == RAMP) begin
                        if (freq_q == target_q) begin
                            state_d = RUN;
                        end else if (step_hit) begin
                            freq_d = (freq_q < target_q) ? freq_q + 10'd1 : freq_q - 10'd1;
                            if (freq_d == target_q) begin
                                state_d = RUN;
                            end
                        end
                    end
                end
                DECEL: begin
                    if (freq_q == FREQ_SLOW) begin
                        state_d = DWELL;
                        start_d = 1'b0;
                        dwell_d = '0;
                    end else if (step_hit) begin
                        freq_d = (freq_q < FREQ_SLOW) ? freq_q + 10'd1 : freq_q - 10'd1;
                    end
                end
                DWELL: begin
                    if (dwell_q == DWELL_W'(DWELL_CYC - 1)) begin
                        dwell_d = '0;
                        if (pend_q) begin
                            state_d  = RAMP;
                            freq_d   = FREQ_SLOW;
                            dir_d    = pend_dir_q;
                            target_d = pend_target_q;
                            start_d  = 1'b1;
                            pend_d   = 1'b0;
                            step_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        at_speed_d = (state_d == RUN);
    end

    assign m3start       = start_q;
    assign m3inv_or_stop = dir_q;
    assign m3freq        = freq_q;
    assign at_speed      = at_speed_q;
    assign state         = state_q;
endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// Directed bench for motoro3_ramp_ctrl with a short ramp divider and dwell.
module tb_motoro3_ramp_ctrl;
    localparam int unsigned RAMP_DIV  = 4;
    localparam int unsigned DWELL_CYC = 8;

    logic       clk;
    logic       nRst;
    logic       estop;
    logic       m3start;
    logic       m3inv_or_stop;
    logic [9:0] m3freq;
    logic       at_speed;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    motoro3_ramp_ctrl_if cmd_if ();

    motoro3_ramp_ctrl #(
        .FREQ_MIN  (10'd1000),
        .FREQ_SLOW (10'd1023),
        .RAMP_DIV  (RAMP_DIV),
        .DWELL_CYC (DWELL_CYC)
    ) dut (
        .clk           (clk),
        .nRst          (nRst),
        .cmd           (cmd_if),
        .estop         (estop),
        .m3start       (m3start),
        .m3inv_or_stop (m3inv_or_stop),
        .m3freq        (m3freq),
        .at_speed      (at_speed),
        .state         (state)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic run, input logic dir, input logic [9:0] freq);
        cmd_if.valid = 1'b1;
        cmd_if.run   = run;
        cmd_if.dir   = dir;
        cmd_if.freq  = freq;
        tick(1);
        cmd_if.valid = 1'b0;
    endtask

    int min_freq;

    initial begin
        nRst         = 1'b0;
        estop        = 1'b0;
        cmd_if.valid = 1'b0;
        cmd_if.run   = 1'b0;
        cmd_if.dir   = 1'b0;
        cmd_if.freq  = 10'd0;

        // Reset values while nRst is low
        tick(2);
        check("rst_state", int'(state), 0);
        check("rst_start", int'(m3start), 0);
        check("rst_dir", int'(m3inv_or_stop), 0);
        check("rst_freq", int'(m3freq), 1023);
        check("rst_atspeed", int'(at_speed), 0);
        nRst = 1'b1;
        tick(1);
        check("idle_ready", int'(cmd_if.ready), 1);

        // Stop command in IDLE does nothing
        send(1'b0, 1'b0, 10'd1010);
        check("idle_stop_state", int'(state), 0);

        // Start: 1023 then 1022, 1021, 1020 at 4-cycle spacing
        send(1'b1, 1'b0, 10'd1020);
        check("start_state", int'(state), 1);
        check("start_m3start", int'(m3start), 1);
        check("start_freq", int'(m3freq), 1023);
        check("start_atspeed", int'(at_speed), 0);
        tick(3);
        check("start_freq_e3", int'(m3freq), 1023);
        tick(1);
        check("start_freq_e4", int'(m3freq), 1022);
        tick(4);
        check("start_freq_e8", int'(m3freq), 1021);
        check("start_state_e8", int'(state), 1);
        tick(4);
        check("start_freq_e12", int'(m3freq), 1020);
        check("start_run", int'(state), 2);
        check("start_atspeed_run", int'(at_speed), 1);
        check("run_ready", int'(cmd_if.ready), 1);

        // Reversal through decel and dwell
        send(1'b1, 1'b1, 10'd1010);
        check("rev_decel", int'(state), 3);
        check("rev_dir_held", int'(m3inv_or_stop), 0);
        check("rev_ready", int'(cmd_if.ready), 0);
        tick(12);
        check("rev_freq_slow", int'(m3freq), 1023);
        check("rev_still_decel", int'(state), 3);
        tick(1);
        check("rev_dwell", int'(state), 4);
        check("rev_dwell_start", int'(m3start), 0);
        tick(7);
        check("rev_dwell_end", int'(state), 4);
        check("rev_dwell_end_start", int'(m3start), 0);
        check("rev_dwell_end_dir", int'(m3inv_or_stop), 0);
        tick(1);
        check("rev_ramp", int'(state), 1);
        check("rev_ramp_start", int'(m3start), 1);
        check("rev_ramp_dir", int'(m3inv_or_stop), 1);
        check("rev_ramp_freq", int'(m3freq), 1023);
        tick(51);
        check("rev_freq_1011", int'(m3freq), 1011);
        check("rev_state_1011", int'(state), 1);
        tick(1);
        check("rev_freq_1010", int'(m3freq), 1010);
        check("rev_run", int'(state), 2);

        // Stop from RUN back to IDLE
        send(1'b0, 1'b0, 10'd0);
        check("stop_decel", int'(state), 3);
        tick(53);
        check("stop_dwell", int'(state), 4);
        check("stop_dwell_start", int'(m3start), 0);
        tick(8);
        check("stop_idle", int'(state), 0);

        // Estop mid-ramp at 1021, with a colliding command
        send(1'b1, 1'b0, 10'd1000);
        tick(8);
        check("es_pre_freq", int'(m3freq), 1021);
        estop        = 1'b1;
        cmd_if.valid = 1'b1;
        cmd_if.run   = 1'b1;
        cmd_if.dir   = 1'b1;
        cmd_if.freq  = 10'd1010;
        #1;
        check("es_ready_low", int'(cmd_if.ready), 0);
        tick(1);
        check("es_start", int'(m3start), 0);
        check("es_freq", int'(m3freq), 1023);
        check("es_state", int'(state), 4);
        check("es_ready", int'(cmd_if.ready), 0);
        check("es_dir_kept", int'(m3inv_or_stop), 0);
        cmd_if.valid = 1'b0;
        tick(19);
        check("es_hold_state", int'(state), 4);
        estop = 1'b0;
        tick(7);
        check("es_release_dwell", int'(state), 4);
        tick(1);
        check("es_idle", int'(state), 0);
        check("es_idle_start", int'(m3start), 0);

        // Clamp: freq 500 ramps to 1000 in 23 steps over 92 cycles
        send(1'b1, 1'b0, 10'd500);
        min_freq = 1023;
        for (int i = 1; i <= 91; i++) begin
            tick(1);
            if (int'(m3freq) < min_freq) min_freq = int'(m3freq);
        end
        check("clamp_freq_e91", int'(m3freq), 1001);
        check("clamp_state_e91", int'(state), 1);
        tick(1);
        if (int'(m3freq) < min_freq) min_freq = int'(m3freq);
        check("clamp_freq_e92", int'(m3freq), 1000);
        check("clamp_run", int'(state), 2);
        tick(10);
        if (int'(m3freq) < min_freq) min_freq = int'(m3freq);
        check("clamp_min_freq", min_freq, 1000);
        send(1'b0, 1'b0, 10'd0);
        tick(101);
        check("clamp_stop_idle", int'(state), 0);

        // Degenerate target equal to start word
        send(1'b1, 1'b0, 10'd1023);
        check("deg_ramp", int'(state), 1);
        tick(1);
        check("deg_run", int'(state), 2);
        check("deg_atspeed", int'(at_speed), 1);
        send(1'b0, 1'b0, 10'd0);
        check("deg_decel", int'(state), 3);
        tick(1);
        check("deg_dwell", int'(state), 4);
        check("deg_dwell_start", int'(m3start), 0);
        tick(8);
        check("deg_idle", int'(state), 0);
        check("deg_idle_start", int'(m3start), 0);

        // Reset mid-decel aborts and stays idle
        send(1'b1, 1'b0, 10'd1020);
        tick(12);
        send(1'b0, 1'b0, 10'd0);
        tick(4);
        check("mid_decel_freq", int'(m3freq), 1021);
        nRst = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_start", int'(m3start), 0);
        check("arst_freq", int'(m3freq), 1023);
        check("arst_atspeed", int'(at_speed), 0);
        tick(2);
        nRst = 1'b1;
        tick(30);
        check("post_rst_state", int'(state), 0);
        check("post_rst_start", int'(m3start), 0);
        check("post_rst_freq", int'(m3freq), 1023);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
